// File: rtl/snow64_instr_fetch_ctrl_pkg.sv
// Shared types and constants for the Snow64 instruction fetch controller.
package PkgSnow64InstrFetch;

  // Default configuration of the fetch path.
  localparam int WIDTH__ADDR_DEFAULT  = 64;
  localparam int WIDTH__INSTR_DEFAULT = 32;
  localparam int FIFO_DEPTH_DEFAULT   = 2;

  // Occupancy counter width: must represent 0..DEPTH inclusive.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int WIDTH__FIFO_COUNT = count_width(FIFO_DEPTH_DEFAULT);

  typedef enum logic [1:0] {
    ST_REQ,    // may issue a request
    ST_WAIT,   // one request in flight, response will be kept
    ST_DRAIN   // one request in flight, response will be discarded
  } fetch_state_t;

  // Buffered instruction with the address it was fetched from (default widths).
  typedef struct packed {
    logic [WIDTH__INSTR_DEFAULT-1:0] instr;
    logic [WIDTH__ADDR_DEFAULT-1:0]  pc;
  } fetch_entry_t;

endpackage

// File: rtl/snow64_instr_fifo.sv
// Small synchronous FIFO holding fetched instructions. Flush dominates push.
module snow64_instr_fifo
  import PkgSnow64InstrFetch::*;
#(
  parameter int  DEPTH   = FIFO_DEPTH_DEFAULT,
  parameter type entry_t = fetch_entry_t,
  localparam int WIDTH__COUNT = count_width(DEPTH),
  localparam int WIDTH__PTR   = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  entry_t                  push_entry,
  input  logic                    pop,
  input  logic                    flush,
  output logic [WIDTH__COUNT-1:0] count,
  output entry_t                  head
);

  entry_t                  mem [DEPTH];
  logic [WIDTH__PTR-1:0]   rd_ptr;
  logic [WIDTH__PTR-1:0]   wr_ptr;
  logic                    push_ok;
  logic                    pop_ok;

  // Guard against overflow/underflow so the counter can never leave 0..DEPTH.
  always_comb begin
    pop_ok  = pop && (count != '0);
    push_ok = push && (count != WIDTH__COUNT'(DEPTH));
  end

  // Pointer and occupancy bookkeeping; flush empties the buffer in one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + WIDTH__COUNT'(push_ok) - WIDTH__COUNT'(pop_ok);
    end
  end

  // Storage write port.
  // NOTE: the storage array is deliberately not reset; the counter alone decides
  // which entries are meaningful, and leaving it unreset keeps it as plain flops/RAM.
  always_ff @(posedge clk) begin
    if (rst_n && !flush && push_ok) mem[wr_ptr] <= push_entry;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/snow64_instr_fetch_ctrl.sv
// Snow64 instruction fetch sequencer: one outstanding memory read, a small
// instruction buffer toward decode, and redirect handling that discards
// buffered and in-flight instructions.
module snow64_instr_fetch_ctrl
  import PkgSnow64InstrFetch::*;
#(
  parameter int                        WIDTH__ADDR  = WIDTH__ADDR_DEFAULT,
  parameter int                        WIDTH__INSTR = WIDTH__INSTR_DEFAULT,
  parameter int                        FIFO_DEPTH   = FIFO_DEPTH_DEFAULT,
  parameter logic [WIDTH__ADDR-1:0]    RESET_PC     = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_halt,
  input  logic                    in_redirect_valid,
  input  logic [WIDTH__ADDR-1:0]  in_redirect_addr,
  output logic                    out_mem_req_valid,
  input  logic                    in_mem_req_ready,
  output logic [WIDTH__ADDR-1:0]  out_mem_req_addr,
  input  logic                    in_mem_resp_valid,
  input  logic [WIDTH__INSTR-1:0] in_mem_resp_data,
  output logic                    out_instr_valid,
  output logic [WIDTH__INSTR-1:0] out_instr,
  output logic [WIDTH__ADDR-1:0]  out_instr_pc,
  input  logic                    in_instr_ready,
  output logic                    out_busy
);

  localparam int WIDTH__COUNT = count_width(FIFO_DEPTH);

  typedef struct packed {
    logic [WIDTH__INSTR-1:0] instr;
    logic [WIDTH__ADDR-1:0]  pc;
  } entry_t;

  localparam logic [WIDTH__ADDR-1:0] ALIGN_MASK = ~WIDTH__ADDR'(3);
  localparam logic [WIDTH__ADDR-1:0] INSTR_STEP = WIDTH__ADDR'(4);

  fetch_state_t             state;
  logic [WIDTH__ADDR-1:0]   fetch_pc;
  logic [WIDTH__ADDR-1:0]   redirect_pc;
  logic [WIDTH__COUNT-1:0]  count;
  entry_t                   head;
  entry_t                   push_entry;
  logic                     room;
  logic                     req_accept;
  logic                     push;
  logic                     pop;

  // Request gating and buffer handshakes. Only one request is ever in flight
  // and ST_REQ means none is, so free space in the buffer is sufficient.
  always_comb begin
    room              = (count < WIDTH__COUNT'(FIFO_DEPTH));
    out_mem_req_valid = rst_n && (state == ST_REQ) && !in_halt &&
                        !in_redirect_valid && room;
    out_mem_req_addr  = fetch_pc;
    req_accept        = out_mem_req_valid && in_mem_req_ready;
    redirect_pc       = in_redirect_addr & ALIGN_MASK;
    // fetch_pc already points past the in-flight word.
    push_entry.instr  = in_mem_resp_data;
    push_entry.pc     = fetch_pc - INSTR_STEP;
    push              = (state == ST_WAIT) && in_mem_resp_valid && !in_redirect_valid;
    out_instr_valid   = rst_n && (count != '0);
    pop               = out_instr_valid && in_instr_ready;
    out_instr         = head.instr;
    out_instr_pc      = head.pc;
    out_busy          = rst_n && ((state != ST_REQ) || (count != '0));
  end

  // Fetch state machine and program counter.
  // NOTE: all state here uses non-blocking assignments so every branch sees the
  // pre-edge values of state and fetch_pc, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_REQ;
      fetch_pc <= RESET_PC & ALIGN_MASK;
    end else begin
      unique case (state)
        ST_REQ: begin
          if (in_redirect_valid) begin
            fetch_pc <= redirect_pc;
          end else if (req_accept) begin
            fetch_pc <= fetch_pc + INSTR_STEP;
            state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (in_redirect_valid) begin
            fetch_pc <= redirect_pc;
            state    <= in_mem_resp_valid ? ST_REQ : ST_DRAIN;
          end else if (in_mem_resp_valid) begin
            state <= ST_REQ;
          end
        end
        ST_DRAIN: begin
          if (in_redirect_valid) fetch_pc <= redirect_pc;
          if (in_mem_resp_valid) state <= ST_REQ;
        end
        default: state <= ST_REQ;
      endcase
    end
  end

  snow64_instr_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (in_redirect_valid),
    .count      (count),
    .head       (head)
  );

endmodule

// File: tb/tb_snow64_instr_fetch_ctrl.sv
// Directed bench for snow64_instr_fetch_ctrl with a 1-cycle memory responder.
module tb_snow64_instr_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_halt;
  logic        in_redirect_valid;
  logic [63:0] in_redirect_addr;
  logic        out_mem_req_valid;
  logic        in_mem_req_ready;
  logic [63:0] out_mem_req_addr;
  logic        in_mem_resp_valid;
  logic [31:0] in_mem_resp_data;
  logic        out_instr_valid;
  logic [31:0] out_instr;
  logic [63:0] out_instr_pc;
  logic        in_instr_ready;
  logic        out_busy;

  logic        mem_auto;
  logic        auto_valid = 1'b0;
  logic [31:0] auto_data  = '0;
  logic        man_valid;
  logic [31:0] man_data;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  snow64_instr_fetch_ctrl #(
    .RESET_PC (64'h1000)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .in_halt           (in_halt),
    .in_redirect_valid (in_redirect_valid),
    .in_redirect_addr  (in_redirect_addr),
    .out_mem_req_valid (out_mem_req_valid),
    .in_mem_req_ready  (in_mem_req_ready),
    .out_mem_req_addr  (out_mem_req_addr),
    .in_mem_resp_valid (in_mem_resp_valid),
    .in_mem_resp_data  (in_mem_resp_data),
    .out_instr_valid   (out_instr_valid),
    .out_instr         (out_instr),
    .out_instr_pc      (out_instr_pc),
    .in_instr_ready    (in_instr_ready),
    .out_busy          (out_busy)
  );

  function automatic logic [31:0] instr_of(input logic [63:0] a);
    return a[31:0] ^ 32'hA5A5_0000;
  endfunction

  // Memory answers exactly one cycle after accepting a request (when enabled).
  always @(posedge clk) begin
    auto_valid <= mem_auto && out_mem_req_valid && in_mem_req_ready;
    auto_data  <= instr_of(out_mem_req_addr);
  end

  assign in_mem_resp_valid = auto_valid | man_valid;
  assign in_mem_resp_data  = man_valid ? man_data : auto_data;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 0; in_halt = 0; in_redirect_valid = 0; in_redirect_addr = '0;
    in_mem_req_ready = 1; in_instr_ready = 1; mem_auto = 1; man_valid = 0; man_data = '0;

    // Reset state
    tick(); tick();
    check("rst_instr_valid", 64'(out_instr_valid), 64'd0);
    check("rst_busy", 64'(out_busy), 64'd0);
    check("rst_req_valid", 64'(out_mem_req_valid), 64'd0);

    // Sequential fetch from RESET_PC
    rst_n = 1; #1;
    check("c0_req_valid", 64'(out_mem_req_valid), 64'd1);
    check("c0_req_addr", out_mem_req_addr, 64'h1000);
    tick();
    check("c1_req_valid", 64'(out_mem_req_valid), 64'd0);
    check("c1_busy", 64'(out_busy), 64'd1);
    check("c1_instr_valid", 64'(out_instr_valid), 64'd0);
    tick();
    check("c2_instr_valid", 64'(out_instr_valid), 64'd1);
    check("c2_pc", out_instr_pc, 64'h1000);
    check("c2_instr", 64'(out_instr), 64'(instr_of(64'h1000)));
    check("c2_req_addr", out_mem_req_addr, 64'h1004);
    tick();
    check("c3_instr_valid", 64'(out_instr_valid), 64'd0);
    tick();
    check("c4_pc", out_instr_pc, 64'h1004);
    check("c4_req_addr", out_mem_req_addr, 64'h1008);

    // Backpressure: buffer fills to two, requests stop
    in_instr_ready = 0; #1;
    tick(); tick();
    check("full_req_valid", 64'(out_mem_req_valid), 64'd0);
    check("full_head_pc", out_instr_pc, 64'h1004);
    tick();
    check("full_req_valid_hold", 64'(out_mem_req_valid), 64'd0);
    check("full_head_stable", out_instr_pc, 64'h1004);
    in_instr_ready = 1; #1;
    tick();
    check("resume_head_pc", out_instr_pc, 64'h1008);
    check("resume_req_valid", 64'(out_mem_req_valid), 64'd1);
    check("resume_req_addr", out_mem_req_addr, 64'h100C);

    // Redirect while waiting with a buffered word; late response is drained
    in_instr_ready = 0; mem_auto = 0; #1;
    tick();
    check("wait_head_valid", 64'(out_instr_valid), 64'd1);
    in_redirect_valid = 1; in_redirect_addr = 64'h2003; #1;
    tick();
    in_redirect_valid = 0; #1;
    check("redir_flushed", 64'(out_instr_valid), 64'd0);
    check("drain_req_valid", 64'(out_mem_req_valid), 64'd0);
    check("drain_busy", 64'(out_busy), 64'd1);
    man_valid = 1; man_data = 32'hDEAD_BEEF; #1;
    tick();
    man_valid = 0; mem_auto = 1; #1;
    check("post_drain_req_valid", 64'(out_mem_req_valid), 64'd1);
    check("post_drain_req_addr", out_mem_req_addr, 64'h2000);
    check("post_drain_empty", 64'(out_instr_valid), 64'd0);
    tick(); tick();
    check("target_pc", out_instr_pc, 64'h2000);
    check("target_instr", 64'(out_instr), 64'(instr_of(64'h2000)));
    check("target_req_addr", out_mem_req_addr, 64'h2004);

    // Redirect coinciding with response and downstream pop
    tick();
    check("coinc_head_pc", out_instr_pc, 64'h2000);
    in_instr_ready = 1; in_redirect_valid = 1; in_redirect_addr = 64'h3000; #1;
    tick();
    in_redirect_valid = 0; #1;
    check("coinc_empty", 64'(out_instr_valid), 64'd0);
    check("coinc_req_valid", 64'(out_mem_req_valid), 64'd1);
    check("coinc_req_addr", out_mem_req_addr, 64'h3000);

    // Redirect in ST_REQ masks the request; address wrap at the top
    in_redirect_valid = 1; in_redirect_addr = 64'hFFFF_FFFF_FFFF_FFFC; #1;
    check("redir_masks_req", 64'(out_mem_req_valid), 64'd0);
    tick();
    in_redirect_valid = 0; #1;
    check("top_req_addr", out_mem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    in_halt = 1; #1;
    tick();
    check("halt_pushed_pc", out_instr_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    check("halt_pushed_instr", 64'(out_instr), 64'(instr_of(64'hFFFF_FFFF_FFFF_FFFC)));
    check("halt_req_valid", 64'(out_mem_req_valid), 64'd0);
    check("halt_busy", 64'(out_busy), 64'd1);
    tick();
    check("halt_drained_busy", 64'(out_busy), 64'd0);
    check("halt_drained_req", 64'(out_mem_req_valid), 64'd0);
    in_halt = 0; #1;
    check("wrap_req_valid", 64'(out_mem_req_valid), 64'd1);
    check("wrap_req_addr", out_mem_req_addr, 64'h0);

    // Reset while a request is in flight and the buffer is occupied
    in_instr_ready = 0;
    tick(); tick();
    mem_auto = 0; #1;
    check("pre_rst_head_pc", out_instr_pc, 64'h0);
    check("pre_rst_req_addr", out_mem_req_addr, 64'h4);
    tick();
    check("pre_rst_busy", 64'(out_busy), 64'd1);
    rst_n = 0; #1;
    check("in_rst_req_valid", 64'(out_mem_req_valid), 64'd0);
    tick();
    check("after_rst_instr_valid", 64'(out_instr_valid), 64'd0);
    check("after_rst_busy", 64'(out_busy), 64'd0);
    rst_n = 1; in_mem_req_ready = 0; man_valid = 1; man_data = 32'hCAFE_F00D; #1;
    check("rerst_req_addr", out_mem_req_addr, 64'h1000);
    tick();
    man_valid = 0; #1;
    check("stale_ignored_valid", 64'(out_instr_valid), 64'd0);
    check("stale_ignored_busy", 64'(out_busy), 64'd0);
    check("stale_ignored_req", 64'(out_mem_req_valid), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
